// File: rtl/level_pkg.sv
// Shared definitions for the level sequencer: state encoding, default
// game constants and a counter-width helper.
package level_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_ADVANCE,
    S_OVER,
    S_WIN
  } state_t;

  localparam logic [4:0] MAX_LEVEL_DEF    = 5'd31;
  localparam logic [1:0] LIVES_DEF        = 2'd3;
  localparam int         PAUSE_CYCLES_DEF = 50_000_000;
  localparam int         BLINK_CYCLES_DEF = 12_500_000;

  // Bits needed to hold a down/up counter spanning 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Pushbutton conditioning: two-flop synchronizer followed by a rising-edge
// detector with a registered one-cycle pulse. All flops holding the button
// level reset to 1, so a button held through reset is seen as "already
// pressed" and only a release followed by a new press produces a pulse.
module btn_edge (
  input  logic CLK,
  input  logic RST,
  input  logic start,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Synchronize the raw button, remember the last synced level, register the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= start;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      pulse   <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/level_sequencer.sv
// Game level sequencer: walks the player through levels, tracks lives,
// blinks the level display during the pause between levels and reports
// win / game-over. All outputs are registered and change on the edge that
// enters the corresponding state.
module level_sequencer
  import level_pkg::*;
#(
  parameter logic [4:0] MAX_LEVEL    = MAX_LEVEL_DEF,
  parameter logic [1:0] LIVES        = LIVES_DEF,
  parameter int         PAUSE_CYCLES = PAUSE_CYCLES_DEF,
  parameter int         BLINK_CYCLES = BLINK_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic       level_done,
  input  logic       life_lost,
  output logic [4:0] current_level,
  output logic       on,
  output logic [1:0] lives,
  output logic       playing,
  output logic       game_over,
  output logic       win
);

  localparam int TW = cnt_width(PAUSE_CYCLES);
  localparam int BW = cnt_width(BLINK_CYCLES);

  // The pause timer counts PAUSE_CYCLES-1 down to 0, so ADVANCE occupies
  // exactly PAUSE_CYCLES cycles including the entry cycle.
  localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] pause_cnt;
  logic [BW-1:0] blink_cnt;
  logic          start_pulse;

  btn_edge u_btn_edge (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .pulse (start_pulse)
  );

  // Main game FSM with registered outputs, pause timer and blink counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      current_level <= 5'd1;
      lives         <= LIVES;
      on            <= 1'b0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      win           <= 1'b0;
      pause_cnt     <= '0;
      blink_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          current_level <= 5'd1;
          lives         <= LIVES;
          on            <= 1'b0;
          if (start_pulse) begin
            state   <= S_PLAY;
            on      <= 1'b1;
            playing <= 1'b1;
          end
        end

        S_PLAY: begin
          // level_done has priority; a coincident life_lost is dropped.
          if (level_done) begin
            playing <= 1'b0;
            on      <= 1'b1;
            if (current_level < MAX_LEVEL) begin
              state         <= S_ADVANCE;
              current_level <= current_level + 5'd1;
              pause_cnt     <= PAUSE_LOAD;
              blink_cnt     <= '0;
            end else begin
              state <= S_WIN;
              win   <= 1'b1;
            end
          end else if (life_lost) begin
            if (lives > 2'd1) begin
              lives <= lives - 2'd1;
            end else begin
              state     <= S_OVER;
              lives     <= 2'd0;
              playing   <= 1'b0;
              game_over <= 1'b1;
            end
          end
        end

        S_ADVANCE: begin
          if (pause_cnt == '0) begin
            state     <= S_PLAY;
            on        <= 1'b1;
            playing   <= 1'b1;
            blink_cnt <= '0;
          end else begin
            pause_cnt <= pause_cnt - 1'b1;
            if (blink_cnt == BLINK_LAST) begin
              blink_cnt <= '0;
              on        <= ~on;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end

        S_OVER, S_WIN: begin
          on <= 1'b1;
          if (start_pulse) begin
            state         <= S_IDLE;
            current_level <= 5'd1;
            lives         <= LIVES;
            on            <= 1'b0;
            game_over     <= 1'b0;
            win           <= 1'b0;
          end
        end

        default: begin
          state         <= S_IDLE;
          current_level <= 5'd1;
          lives         <= LIVES;
          on            <= 1'b0;
          playing       <= 1'b0;
          game_over     <= 1'b0;
          win           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 MAX_LEVEL, 5'd31, highest playable level (1..31).
REQ-002 LIVES, 2'd3, lives granted at game start (1..3).
REQ-003 PAUSE_CYCLES, 50_000_000, ADVANCE dwell in CLK cycles (>=2).
REQ-004 BLINK_CYCLES, 12_500_000, half-period of `on` blink during ADVANCE (>=1).
REQ-005 CLK  input  1  single system clock, all logic on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  raw pushbutton, asynchronous to CLK, active-high.
REQ-008 level_done  input  1  one-cycle CLK-synchronous pulse: current level cleared.
REQ-009 life_lost  input  1  one-cycle CLK-synchronous pulse: player hit.
REQ-010 current_level  output  5  level number for the level display, registered.
REQ-011 on  output  1  level display enable, registered.
REQ-012 lives  output  2  remaining lives, registered.
REQ-013 playing  output  1  high only in PLAY, registered.
REQ-014 game_over  output  1  high only in OVER, registered.
REQ-015 win  output  1  high only in WIN, registered.

Function
REQ-016 start SHALL pass a 2-flop synchronizer then rising-edge detector, giving a one-cycle start_pulse 3 CLK edges after start rises.
REQ-017 States SHALL be IDLE, PLAY, ADVANCE, OVER, WIN; every output SHALL change on the clock edge that enters the state.
REQ-018 IDLE: current_level=1, lives=LIVES, on=0; start_pulse -> PLAY.
REQ-019 PLAY: on=1; level_done with current_level<MAX_LEVEL -> current_level+1, load timer, -> ADVANCE.
REQ-020 PLAY: level_done with current_level==MAX_LEVEL -> WIN, level unchanged (no wrap, never exceeds MAX_LEVEL).
REQ-021 PLAY: life_lost with lives>1 -> lives-1, stay PLAY; with lives==1 -> lives=0, -> OVER.
REQ-022 level_done and life_lost in same cycle: level_done SHALL win, life_lost discarded.
REQ-023 ADVANCE: on SHALL start at 1 and toggle every BLINK_CYCLES; level_done, life_lost, start_pulse ignored.
REQ-024 ADVANCE SHALL last exactly PAUSE_CYCLES cycles, then -> PLAY with on=1.
REQ-025 OVER and WIN: on=1, current_level holds reached level; start_pulse -> IDLE.
REQ-026 start_pulse in PLAY or ADVANCE SHALL be ignored; level_done/life_lost outside PLAY ignored.
REQ-027 Timer SHALL be wide enough for PAUSE_CYCLES with no overflow; blink counter resets on ADVANCE entry.

Reset
REQ-028 RST asserted SHALL immediately force IDLE, current_level=1, lives=LIVES, on=0, playing/game_over/win=0, timers=0.
REQ-029 Synchronizer and edge flops SHALL reset to 1 so a button held through reset produces no start_pulse until released and re-pressed.
REQ-030 RST mid-ADVANCE or mid-PLAY SHALL abandon the game with no residual pulse after release.

Structure
REQ-031 Package level_pkg SHALL hold the state enumeration and default MAX_LEVEL/LIVES constants.
REQ-032 Synchronizer plus edge detector SHALL be sub-module btn_edge, instantiated once.

Verification (MAX_LEVEL=3, LIVES=2, PAUSE_CYCLES=8, BLINK_CYCLES=2)
REQ-033 Reset then start pulse -> playing=1, current_level=1, lives=2, on=1 within 4 cycles.
REQ-034 level_done in PLAY -> current_level=2, on pattern 1,1,0,0,1,1,0,0 over 8 cycles, then PLAY with on=1.
REQ-035 level_done at levels 1,2,3 -> win=1, current_level=3; start pulse -> IDLE, current_level=1, on=0.
REQ-036 Two life_lost pulses -> lives 2,1,0, game_over=1; simultaneous level_done+life_lost -> level+1, lives unchanged.
REQ-037 start held across RST release -> no start_pulse; RST asserted mid-ADVANCE -> IDLE outputs same cycle.
